tpu_sequencer: RTL and testbench
================================

Name: tpu_sequencer

Overview:
- Top-level run controller for the tiny TPU datapath (serial input_control, systolic core, serial output_control).
- Accepts a host start command and drives the core's init/load_en; gates the host's serial x/y bit streams into the core; times the compute phase; captures the serialized result stream gated by tx_ready.
- Sits between the host pin interface and the datapath instance.

Parameters:
- D_W, 8, operand width in bits.
- N, 2, systolic array dimension (N x N).
- WORD, 8, serial word width used by the input loader.
- COMPUTE_CYCLES, 6, cycles held in COMPUTE after load; must be >= 3*N-2.
- TIMEOUT, 255, max cycles waited in DRAIN for tx_ready (only with the optional feature).
- Derived localparams: LOAD_BITS = N*N*WORD (32), OUT_BITS = N*N*2*D_W (64), CNT_W = $clog2(max of LOAD_BITS, OUT_BITS, COMPUTE_CYCLES, TIMEOUT)+1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  run request, sampled in IDLE only.
- abort  in  1  synchronous abort, any state.
- host_x  in  1  serial x operand bit from host.
- host_y  in  1  serial y operand bit from host.
- host_rdy  out  1  high while bits are being accepted (LOAD).
- core_x  out  1  to datapath data_in_x.
- core_y  out  1  to datapath data_in_y.
- load_en  out  1  to datapath load_en.
- init  out  1  to datapath init (clear pulse).
- core_z  in  1  from datapath data_out_z.
- tx_ready  in  1  from datapath; high = core_z bit valid this cycle.
- res_bit  out  1  registered result bit.
- res_valid  out  1  registered qualifier for res_bit.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on run completion.
- err  out  1  one-cycle pulse on watchdog expiry.

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0; host_rdy, load_en, init, res_bit, res_valid, busy, done, err = 0.
- FSM states: IDLE, CLEAR, LOAD, COMPUTE, DRAIN, DONE. Single counter cnt (CNT_W bits), cleared on every state entry.
- IDLE: start=1 -> CLEAR. Start is ignored in all other states (no queuing).
- CLEAR: init=1 for exactly 1 cycle -> LOAD.
- LOAD:
  - load_en=1 and host_rdy=1.
  - core_x=host_x and core_y=host_y, combinational, zero latency.
  - cnt increments each cycle; after LOAD_BITS cycles (cnt==LOAD_BITS-1) -> COMPUTE.
  - Outside LOAD, core_x=core_y=0.
- COMPUTE: all core controls 0 for COMPUTE_CYCLES cycles -> DRAIN.
- DRAIN:
  - Each cycle with tx_ready=1: res_bit<=core_z, res_valid<=1 (1-cycle latency), cnt increments.
  - tx_ready=0 cycles: res_valid<=0, cnt holds.
  - The OUT_BITS-th valid bit -> DONE.
  - Gaps in tx_ready are legal.
- DONE: done=1 for 1 cycle -> IDLE; res_valid carrying the last bit may coincide with done.
- Outputs: busy = (state != IDLE), registered with state.
- Boundary conditions:
  - abort=1 in any non-IDLE state: IDLE next cycle; load_en/init/res_valid deassert next cycle; no done, no err. abort in IDLE: no effect.
  - abort and start in the same cycle in IDLE: abort wins, stay IDLE.
  - tx_ready high outside DRAIN: ignored, res_valid stays 0.
  - rst deasserted mid-run: restart from IDLE; the host must issue a new start.
- Counter never wraps: every terminal compare is an equality on the last count.

Optional Feature:
- Macro TPU_SEQ_WDOG_EN.
- Defined:
  - In DRAIN, a separate watchdog counter increments every cycle with tx_ready=0 and clears on any tx_ready=1 cycle.
  - When it reaches TIMEOUT: err=1 for 1 cycle, state -> IDLE, no done.
- Undefined:
  - No watchdog logic; DRAIN waits indefinitely; err tied to 0.

Test Plan:
- Nominal run: pulse start.
  - init high the cycle after start.
  - load_en/host_rdy high for exactly 32 cycles with host_x pattern 0xA5A5A5A5 mirrored on core_x.
  - 6 idle cycles.
  - Drive tx_ready=1 for 64 cycles with core_z = 64-bit pattern 0x0123456789ABCDEF -> identical bits on res_bit with res_valid, 1 cycle later; done pulses once; busy falls.
- Gapped drain: tx_ready toggling 1,0,1,0 over 128 cycles -> exactly 64 res_valid pulses, done after the 64th, cnt frozen during gaps.
- Abort in LOAD at bit 10 -> IDLE next cycle; load_en=0, busy=0, no done. A following start runs a full 32-bit load.
- Async reset asserted in COMPUTE -> all outputs 0 immediately, without a clock edge; after release, start yields normal CLEAR/LOAD timing.
- start re-asserted during LOAD and DRAIN -> ignored: exactly one done per run, no second CLEAR pulse.
- With TPU_SEQ_WDOG_EN and TIMEOUT=255, hold tx_ready=0 in DRAIN -> err pulses after 255 cycles, state IDLE, done never asserted. Without the macro, the same stimulus keeps busy=1 and err=0 for more than 1000 cycles.

Source files
------------

// File: rtl/tpu_sequencer.sv
// tpu_sequencer: top-level run controller for the tiny TPU datapath.
// Sequence: IDLE -> CLEAR (init pulse) -> LOAD (serial x/y bits into core)
// -> COMPUTE (fixed wait) -> DRAIN (capture core_z stream) -> DONE -> IDLE.
// Optional drain watchdog: define TPU_SEQ_WDOG_EN to enable it; otherwise
// DRAIN waits forever for tx_ready and err stays 0.
// Handshake: host_x/host_y are consumed on every cycle host_rdy=1 (no host
// backpressure); core_z is consumed on every DRAIN cycle with tx_ready=1 and
// reappears one cycle later on res_bit qualified by res_valid.
module tpu_sequencer #(
  parameter int D_W            = 8,
  parameter int N              = 2,
  parameter int WORD           = 8,
  parameter int COMPUTE_CYCLES = 6,
  parameter int TIMEOUT        = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       host_x,
  input  logic       host_y,
  output logic       host_rdy,
  output logic       core_x,
  output logic       core_y,
  output logic       load_en,
  output logic       init,
  input  logic       core_z,
  input  logic       tx_ready,
  output logic       res_bit,
  output logic       res_valid,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] state_dbg
);

  localparam int LOAD_BITS = N * N * WORD;
  localparam int OUT_BITS  = N * N * 2 * D_W;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CNT_MAX = max2(max2(LOAD_BITS, OUT_BITS), max2(COMPUTE_CYCLES, TIMEOUT));
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  // Terminal counts: every exit is an equality on the last count value.
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_BITS - 1);
  localparam logic [CNT_W-1:0] COMP_LAST = CNT_W'(COMPUTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] OUT_LAST  = CNT_W'(OUT_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_LOAD    = 3'd2,
    S_COMPUTE = 3'd3,
    S_DRAIN   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

`ifdef TPU_SEQ_WDOG_EN
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] wd_cnt;
`endif

  assign state_dbg = state;

  // Host bit streams reach the core only while loading, with no added latency.
  assign core_x = (state == S_LOAD) & host_x;
  assign core_y = (state == S_LOAD) & host_y;

  // Run FSM; every control output is registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      host_rdy  <= 1'b0;
      load_en   <= 1'b0;
      init      <= 1'b0;
      res_bit   <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef TPU_SEQ_WDOG_EN
      wd_cnt    <= '0;
`endif
    end else if (abort && (state != S_IDLE)) begin
      state     <= S_IDLE;
      cnt       <= '0;
      host_rdy  <= 1'b0;
      load_en   <= 1'b0;
      init      <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      init      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      res_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          // abort alongside start keeps the sequencer idle
          if (start && !abort) begin
            state <= S_CLEAR;
            cnt   <= '0;
            init  <= 1'b1;
            busy  <= 1'b1;
          end
        end
        S_CLEAR: begin
          state    <= S_LOAD;
          cnt      <= '0;
          load_en  <= 1'b1;
          host_rdy <= 1'b1;
        end
        S_LOAD: begin
          if (cnt == LOAD_LAST) begin
            state    <= S_COMPUTE;
            cnt      <= '0;
            load_en  <= 1'b0;
            host_rdy <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_COMPUTE: begin
          if (cnt == COMP_LAST) begin
            state <= S_DRAIN;
            cnt   <= '0;
`ifdef TPU_SEQ_WDOG_EN
            wd_cnt <= '0;
`endif
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_DRAIN: begin
          if (tx_ready) begin
            res_bit   <= core_z;
            res_valid <= 1'b1;
`ifdef TPU_SEQ_WDOG_EN
            wd_cnt    <= '0;
`endif
            if (cnt == OUT_LAST) begin
              state <= S_DONE;
              cnt   <= '0;
              done  <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
`ifdef TPU_SEQ_WDOG_EN
          else if (wd_cnt == WD_LAST) begin
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + CNT_ONE;
          end
`endif
        end
        S_DONE: begin
          state <= S_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          cnt      <= '0;
          load_en  <= 1'b0;
          host_rdy <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_sequencer.sv
// tb_tpu_sequencer: directed bench for tpu_sequencer with default parameters
// (32 load bits, 6 compute cycles, 64 result bits, watchdog timeout 255).
module tb_tpu_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, abort, host_x, host_y, core_z, tx_ready;
  logic       host_rdy, core_x, core_y, load_en, init;
  logic       res_bit, res_valid, busy, done, err;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  logic [0:0] exp_q[$];

  tpu_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .host_x    (host_x),
    .host_y    (host_y),
    .host_rdy  (host_rdy),
    .core_x    (core_x),
    .core_y    (core_y),
    .load_en   (load_en),
    .init      (init),
    .core_z    (core_z),
    .tx_ready  (tx_ready),
    .res_bit   (res_bit),
    .res_valid (res_valid),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // clock and global time limit
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Pulse start from IDLE, then stream 32 bits; optionally abort at bit abort_at
  // or re-assert start mid-load.
  task automatic run_load(input logic [31:0] xp, input logic [31:0] yp,
                          input int abort_at, input bit restart);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("clear_state", 64'(state_dbg), 64'(1));
    check("clear_init", 64'(init), 64'(1));
    check("clear_busy", 64'(busy), 64'(1));
    check("clear_load_en", 64'(load_en), 64'(0));
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check("load_state", 64'(state_dbg), 64'(2));
      check("load_en", 64'(load_en), 64'(1));
      check("load_host_rdy", 64'(host_rdy), 64'(1));
      check("load_init", 64'(init), 64'(0));
      host_x = xp[31-i];
      host_y = yp[31-i];
      start  = restart && (i == 5);
      #1;
      check("load_core_x", 64'(core_x), 64'(xp[31-i]));
      check("load_core_y", 64'(core_y), 64'(yp[31-i]));
      if (i == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_state", 64'(state_dbg), 64'(0));
        check("abort_load_en", 64'(load_en), 64'(0));
        check("abort_host_rdy", 64'(host_rdy), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        return;
      end
    end
    start = 1'b0;
  endtask

  // Six COMPUTE cycles with host bits and tx_ready high (must be ignored);
  // optionally assert async reset in cycle rst_at.
  task automatic run_compute(input int rst_at);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check("cmp_state", 64'(state_dbg), 64'(3));
      check("cmp_load_en", 64'(load_en), 64'(0));
      check("cmp_host_rdy", 64'(host_rdy), 64'(0));
      check("cmp_res_valid", 64'(res_valid), 64'(0));
      check("cmp_busy", 64'(busy), 64'(1));
      host_x   = 1'b1;
      host_y   = 1'b1;
      tx_ready = 1'b1;
      #1;
      check("cmp_core_x", 64'(core_x), 64'(0));
      check("cmp_core_y", 64'(core_y), 64'(0));
      if (j == rst_at) begin
        rst = 1'b0;
        #1;
        check("arst_state", 64'(state_dbg), 64'(0));
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_init", 64'(init), 64'(0));
        check("arst_res", 64'({res_bit, res_valid, done, err}), 64'(0));
        check("arst_load", 64'({load_en, host_rdy, core_x, core_y}), 64'(0));
        @(negedge clk);
        rst      = 1'b1;
        tx_ready = 1'b0;
        host_x   = 1'b0;
        host_y   = 1'b0;
        return;
      end
    end
    host_x = 1'b0;
    host_y = 1'b0;
  endtask

  // Feed 64 core_z bits MSB first; scoreboard expects each on res_bit one
  // cycle after it is offered with tx_ready=1.
  task automatic run_drain(input logic [63:0] pat, input bit gapped, input bit restart);
    int         sent   = 0;
    int         dones  = 0;
    int         valids = 0;
    bit         prev_tx = 1'b0;
    bit         fin     = 1'b0;
    logic [0:0] e;
    exp_q.delete();
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      @(negedge clk);
      if (cyc == 0) check("drain_state", 64'(state_dbg), 64'(4));
      check("drain_busy", 64'(busy), 64'(1));
      check("drain_valid", 64'(res_valid), 64'(prev_tx));
      if (res_valid) begin
        valids++;
        if (exp_q.size() == 0) check("drain_extra_bit", 64'(exp_q.size()), 64'(1));
        else begin
          e = exp_q.pop_front();
          check("drain_bit", 64'(res_bit), 64'(e));
        end
      end
      check("drain_done", 64'(done), 64'(prev_tx && (sent == 64)));
      if (done) dones++;
      start = restart && (cyc == 3);
      if (sent == 64) begin
        tx_ready = 1'b0;
        fin      = 1'b1;
        check("done_state", 64'(state_dbg), 64'(5));
      end else begin
        tx_ready = gapped ? ((cyc % 2) == 0) : 1'b1;
        if (tx_ready) begin
          core_z = pat[63-sent];
          exp_q.push_back(core_z);
          sent++;
        end
        prev_tx = tx_ready;
      end
    end
    start = 1'b0;
    check("drain_sent", 64'(sent), 64'(64));
    check("drain_valids", 64'(valids), 64'(64));
    check("drain_dones", 64'(dones), 64'(1));
    @(negedge clk);
    check("post_state", 64'(state_dbg), 64'(0));
    check("post_busy", 64'(busy), 64'(0));
    check("post_done", 64'(done), 64'(0));
    check("post_valid", 64'(res_valid), 64'(0));
    @(negedge clk);
    check("post_no_clear", 64'(init), 64'(0));
  endtask

  initial begin
    int d0;
    int busy_drop;
    int err_seen;
    rst = 1'b0; start = 1'b0; abort = 1'b0; host_x = 1'b0; host_y = 1'b0;
    core_z = 1'b0; tx_ready = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_state", 64'(state_dbg), 64'(0));
    check("rst_outs", 64'({host_rdy, load_en, init, res_bit, res_valid, busy, done, err}), 64'(0));
    rst = 1'b1;

    // abort with start in IDLE: stays idle; tx_ready in IDLE ignored
    @(negedge clk);
    start = 1'b1; abort = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0; tx_ready = 1'b0;
    check("abort_start_state", 64'(state_dbg), 64'(0));
    check("abort_start_init", 64'(init), 64'(0));
    check("abort_start_busy", 64'(busy), 64'(0));
    check("idle_tx_valid", 64'(res_valid), 64'(0));

    // nominal run
    run_load(32'hA5A5_A5A5, 32'h3C96_C35A, -1, 1'b0);
    run_compute(-1);
    run_drain(64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);

    // gapped drain
    run_load(32'h1234_5678, 32'hFEDC_BA98, -1, 1'b0);
    run_compute(-1);
    run_drain(64'hF0E1_D2C3_B4A5_9687, 1'b1, 1'b0);

    // abort in LOAD at bit 10, then a full run
    d0 = done_cnt;
    run_load(32'hFFFF_0000, 32'h0F0F_0F0F, 10, 1'b0);
    repeat (3) @(negedge clk);
    check("abort_idle_busy", 64'(busy), 64'(0));
    check("abort_no_done", 64'(done_cnt), 64'(d0));
    run_load(32'hC0DE_CAFE, 32'h5555_AAAA, -1, 1'b0);
    run_compute(-1);
    run_drain(64'hDEAD_BEEF_0BAD_F00D, 1'b0, 1'b0);

    // async reset in COMPUTE, then a normal run
    run_load(32'h8000_0001, 32'h7FFF_FFFE, -1, 1'b0);
    run_compute(2);
    run_load(32'h0F1E_2D3C, 32'h4B5A_6978, -1, 1'b0);
    run_compute(-1);
    run_drain(64'h1357_9BDF_2468_ACE0, 1'b0, 1'b0);

    // start re-asserted during LOAD and DRAIN is ignored
    run_load(32'h9696_6969, 32'hAAAA_5555, -1, 1'b1);
    run_compute(-1);
    run_drain(64'hAAAA_5555_0000_FFFF, 1'b1, 1'b1);

    // DRAIN with tx_ready held low
    d0 = done_cnt;
    busy_drop = 0;
    err_seen = 0;
    run_load(32'h0000_FFFF, 32'hFFFF_0000, -1, 1'b0);
    run_compute(-1);
`ifdef TPU_SEQ_WDOG_EN
    for (int k = 0; k < 260; k++) begin
      @(negedge clk);
      tx_ready = 1'b0;
      if (err) err_seen++;
      if (k == 254) check("wd_pre_err", 64'({busy, err}), 64'(2'b10));
      if (k == 255) check("wd_err", 64'({busy, err, state_dbg}), 64'({1'b0, 1'b1, 3'd0}));
      if (k == 256) check("wd_post", 64'({busy, err}), 64'(2'b00));
    end
    check("wd_err_pulses", 64'(err_seen), 64'(1));
    check("wd_no_done", 64'(done_cnt), 64'(d0));
`else
    for (int k = 0; k < 1100; k++) begin
      @(negedge clk);
      tx_ready = 1'b0;
      if (!busy) busy_drop++;
      if (err) err_seen++;
    end
    check("nowd_busy_drops", 64'(busy_drop), 64'(0));
    check("nowd_err", 64'(err_seen), 64'(0));
    check("nowd_state", 64'(state_dbg), 64'(4));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("drain_abort_state", 64'(state_dbg), 64'(0));
    check("drain_abort_outs", 64'({busy, done, err, res_valid}), 64'(0));
    check("drain_abort_no_done", 64'(done_cnt), 64'(d0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
